// File: rtl/updown_counter_if.sv
// Bus bundle for updown_counter: control/load inputs and count/flag outputs.
// Revision 1.0
`default_nettype none

interface updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] load_in;
  logic [WIDTH-1:0] mod_max;
  logic             flag_clr;
  logic [WIDTH-1:0] c_out;
  logic             tc;
  logic             overflow;
  logic             underflow;

  modport master (
    output EN, UP, LOAD, load_in, mod_max, flag_clr,
    input  c_out, tc, overflow, underflow
  );

  modport slave (
    input  EN, UP, LOAD, load_in, mod_max, flag_clr,
    output c_out, tc, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/updown_counter.sv
// Prescaled up/down modulo counter with load, wrap/saturate modes and sticky flags.
// Revision 1.0
`default_nettype none

module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  wire logic        CLK,
  input  wire logic        RST_N,
  updown_counter_if.slave  bus
);

  localparam int           PW         = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] c_out_q, c_out_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  always_comb begin
    c_out_d = c_out_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // Clear first so a boundary event on the same edge overrides it.
    if (bus.flag_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (bus.LOAD) begin
      c_out_d = (bus.load_in > bus.mod_max) ? bus.mod_max : bus.load_in;
      pcnt_d  = '0;
    end else if (bus.EN) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        if (bus.UP) begin
          if (c_out_q < bus.mod_max) begin
            c_out_d = c_out_q + WIDTH'(1);
          end else begin
            ovf_d   = 1'b1;
            tc_d    = 1'b1;
            c_out_d = (SATURATE != 0) ? bus.mod_max : '0;
          end
        end else begin
          if (c_out_q == '0) begin
            unf_d   = 1'b1;
            tc_d    = 1'b1;
            c_out_d = (SATURATE != 0) ? '0 : bus.mod_max;
          end else if (c_out_q > bus.mod_max) begin
            c_out_d = bus.mod_max;
          end else begin
            c_out_d = c_out_q - WIDTH'(1);
          end
        end
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_out_q <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      c_out_q <= c_out_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.c_out     = c_out_q;
  assign bus.tc        = tc_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter variants (wrap, saturate, prescale-3) share stimulus.
// Revision 1.0
`default_nettype none

module tb_updown_counter;

  localparam int W = 4;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] c;
    logic         tc;
    logic         ov;
    logic         un;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic         en = 0, up = 0, load = 0, fclr = 0;
  logic [W-1:0] lin = '0, mm = '0;

  updown_counter_if #(.WIDTH(W)) bus_a ();
  updown_counter_if #(.WIDTH(W)) bus_b ();
  updown_counter_if #(.WIDTH(W)) bus_c ();

  assign bus_a.EN = en;  assign bus_a.UP = up;  assign bus_a.LOAD = load;
  assign bus_a.load_in = lin;  assign bus_a.mod_max = mm;  assign bus_a.flag_clr = fclr;
  assign bus_b.EN = en;  assign bus_b.UP = up;  assign bus_b.LOAD = load;
  assign bus_b.load_in = lin;  assign bus_b.mod_max = mm;  assign bus_b.flag_clr = fclr;
  assign bus_c.EN = en;  assign bus_c.UP = up;  assign bus_c.LOAD = load;
  assign bus_c.load_in = lin;  assign bus_c.mod_max = mm;  assign bus_c.flag_clr = fclr;

  updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(0)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(bus_a));
  updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(1)) dut_b (.CLK(CLK), .RST_N(RST_N), .bus(bus_b));
  updown_counter #(.WIDTH(W), .PRESCALE(3), .SATURATE(0)) dut_c (.CLK(CLK), .RST_N(RST_N), .bus(bus_c));

  logic [W-1:0] act_c [NDUT];
  logic         act_tc[NDUT], act_ov[NDUT], act_un[NDUT];
  assign act_c[0] = bus_a.c_out;  assign act_tc[0] = bus_a.tc;
  assign act_ov[0] = bus_a.overflow;  assign act_un[0] = bus_a.underflow;
  assign act_c[1] = bus_b.c_out;  assign act_tc[1] = bus_b.tc;
  assign act_ov[1] = bus_b.overflow;  assign act_un[1] = bus_b.underflow;
  assign act_c[2] = bus_c.c_out;  assign act_tc[2] = bus_c.tc;
  assign act_ov[2] = bus_c.overflow;  assign act_un[2] = bus_c.underflow;

  // Reference model state, one slot per variant.
  int prescale[NDUT] = '{1, 1, 3};
  int saturate[NDUT] = '{0, 1, 0};
  int m_cnt[NDUT], m_pc[NDUT];
  bit m_tc[NDUT], m_ov[NDUT], m_un[NDUT];

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i] = 0; m_pc[i] = 0; m_tc[i] = 0; m_ov[i] = 0; m_un[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int mx;
    bit set_ov, set_un, step;
    mx = int'(mm);
    for (int i = 0; i < NDUT; i++) begin
      set_ov = 0; set_un = 0; step = 0;
      if (load) begin
        m_cnt[i] = (int'(lin) < mx) ? int'(lin) : mx;
        m_pc[i]  = 0;
      end else if (en) begin
        if (m_pc[i] == prescale[i] - 1) begin
          m_pc[i] = 0;
          step = 1;
        end else begin
          m_pc[i]++;
        end
      end
      if (step && up) begin
        if (m_cnt[i] < mx) m_cnt[i]++;
        else begin set_ov = 1; m_cnt[i] = saturate[i] ? mx : 0; end
      end else if (step) begin
        if (m_cnt[i] == 0) begin set_un = 1; m_cnt[i] = saturate[i] ? 0 : mx; end
        else if (m_cnt[i] > mx) m_cnt[i] = mx;
        else m_cnt[i]--;
      end
      m_tc[i] = set_ov | set_un;
      if (fclr) begin m_ov[i] = 0; m_un[i] = 0; end
      if (set_ov) m_ov[i] = 1;
      if (set_un) m_un[i] = 1;
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      e.idx = 2'(i);
      e.c   = W'(m_cnt[i]);
      e.tc  = m_tc[i];
      e.ov  = m_ov[i];
      e.un  = m_un[i];
      sb.push_back(e);
    end
  endfunction

  // One clock edge with the currently driven inputs; returns at edge+1.
  task automatic cycle();
    @(posedge CLK);
    #1;
    if (!RST_N) model_reset();
    else model_edge();
    push_expected();
  endtask

  task automatic drive(input bit e, input bit u, input bit l, input bit fc,
                       input int li, input int mx);
    en = e; up = u; load = l; fclr = fc; lin = W'(li); mm = W'(mx);
  endtask

  task automatic async_reset(input int hold_cycles);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d async-reset c_out", i), int'(act_c[i]), 0);
      check($sformatf("dut%0d async-reset flags", i),
            int'({act_tc[i], act_ov[i], act_un[i]}), 0);
    end
    repeat (hold_cycles) cycle();
    RST_N = 1'b1;
  endtask

  // Monitor: every edge's outputs are compared against the queued prediction.
  initial begin
    exp_t e;
    int k;
    forever begin
      @(negedge CLK);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        k = int'(e.idx);
        check($sformatf("dut%0d c_out", k), int'(act_c[k]), int'(e.c));
        check($sformatf("dut%0d tc", k), int'(act_tc[k]), int'(e.tc));
        check($sformatf("dut%0d overflow", k), int'(act_ov[k]), int'(e.ov));
        check($sformatf("dut%0d underflow", k), int'(act_un[k]), int'(e.un));
      end
    end
  end

  initial begin
    model_reset();
    RST_N = 1'b0;
    drive(1, 1, 0, 0, 0, 9);
    repeat (2) cycle();
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d reset c_out", i), int'(act_c[i]), 0);
    RST_N = 1'b1;

    // Wrap up through 9 -> 0.
    drive(1, 1, 0, 0, 0, 9);
    repeat (10) cycle();
    check("wrapup c_out", int'(bus_a.c_out), 0);
    check("wrapup tc", int'(bus_a.tc), 1);
    check("wrapup overflow", int'(bus_a.overflow), 1);
    drive(0, 1, 0, 0, 0, 9);
    cycle();
    check("wrapup tc drop", int'(bus_a.tc), 0);
    check("wrapup overflow sticky", int'(bus_a.overflow), 1);

    // Wrap down from 0, then clear flags.
    drive(1, 0, 0, 0, 0, 9);
    cycle();
    check("wrapdown c_out", int'(bus_a.c_out), 9);
    check("wrapdown underflow", int'(bus_a.underflow), 1);
    drive(0, 0, 0, 1, 0, 9);
    cycle();
    check("flag_clr underflow", int'(bus_a.underflow), 0);

    // Saturation at 15.
    drive(0, 1, 1, 0, 14, 15);
    cycle();
    drive(1, 1, 0, 0, 0, 15);
    repeat (3) cycle();
    check("saturate c_out", int'(bus_b.c_out), 15);
    check("saturate overflow", int'(bus_b.overflow), 1);

    // Prescaler: 9 enabled cycles give 3 steps; idle cycles delay the next.
    drive(0, 1, 1, 0, 0, 9);
    cycle();
    drive(1, 1, 0, 0, 0, 9);
    repeat (9) cycle();
    check("prescale 9 cycles", int'(bus_c.c_out), 3);
    cycle();
    drive(0, 1, 0, 0, 0, 9);
    repeat (2) cycle();
    drive(1, 1, 0, 0, 0, 9);
    cycle();
    check("prescale idle hold", int'(bus_c.c_out), 3);
    cycle();
    check("prescale step after idle", int'(bus_c.c_out), 4);

    // Load priority over enable, with clamping to mod_max.
    drive(1, 1, 1, 0, 12, 9);
    cycle();
    check("load clamp c_out", int'(bus_a.c_out), 9);
    check("load no tc", int'(bus_a.tc), 0);

    // Clear and overflow on the same edge: set wins.
    drive(1, 1, 0, 1, 0, 9);
    cycle();
    check("clr vs set overflow", int'(bus_a.overflow), 1);

    // Async reset with count 7 and overflow set, then full prescale after release.
    drive(0, 1, 1, 0, 7, 9);
    cycle();
    drive(0, 1, 0, 0, 0, 9);
    cycle();
    async_reset(2);
    drive(1, 1, 0, 0, 0, 9);
    repeat (2) cycle();
    check("post-reset prescale hold", int'(bus_c.c_out), 0);
    cycle();
    check("post-reset first step", int'(bus_c.c_out), 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit l;
      l = ($urandom % 16) == 0;
      if (($urandom % 40) == 0) mm = W'($urandom % 16);
      en   = ($urandom % 4) != 0;
      up   = $urandom % 2;
      load = l;
      lin  = W'($urandom % 16);
      fclr = !l && (($urandom % 8) == 0);
      if (($urandom % 150) == 0) async_reset(1);
      else cycle();
    end

    drive(0, 0, 0, 0, 0, int'(mm));
    repeat (2) @(negedge CLK);
    #1;
    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter and load width in bits, legal range 2..32.
REQ-002 SHALL have parameter PRESCALE, default 1: number of enabled cycles per count step, legal range 1..256.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port EN, input, 1 bit: count enable.
REQ-007 SHALL have port UP, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-008 SHALL have port LOAD, input, 1 bit: synchronous parallel load.
REQ-009 SHALL have port load_in, input, WIDTH bits: load value.
REQ-010 SHALL have port mod_max, input, WIDTH bits: terminal value; the count range is 0..mod_max inclusive.
REQ-011 SHALL have port flag_clr, input, 1 bit: clears the sticky flags.
REQ-012 SHALL have port c_out, output, WIDTH bits: registered count.
REQ-013 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set on a step up from the upper bound.
REQ-015 SHALL have port underflow, output, 1 bit: sticky flag set on a step down from 0.

Function
REQ-016 SHALL keep an internal prescale counter pcnt of width clog2(PRESCALE)+1; a step occurs on an edge where EN=1, LOAD=0 and pcnt==PRESCALE-1.
- pcnt increments on every EN=1 edge otherwise, wraps to 0 on a step, and holds when EN=0.
REQ-017 SHALL give LOAD priority over EN.
- On LOAD=1: c_out <= min(load_in, mod_max), pcnt <= 0, no step, no flag change, no tc.
REQ-018 SHALL, on an up step with c_out < mod_max, set c_out <= c_out+1.
REQ-019 SHALL, on an up step with c_out >= mod_max, set overflow <= 1 and tc <= 1.
- SATURATE=0: c_out <= 0.
- SATURATE=1: c_out <= mod_max.
REQ-020 SHALL, on a down step with c_out > 0, set c_out <= c_out-1; if c_out > mod_max, set c_out <= mod_max instead.
REQ-021 SHALL, on a down step with c_out == 0, set underflow <= 1 and tc <= 1.
- SATURATE=0: c_out <= mod_max.
- SATURATE=1: c_out holds at 0.
REQ-022 SHALL drive tc high for exactly the one cycle following a boundary step and low at all other times.
REQ-023 SHALL, when flag_clr=1, clear overflow and underflow on that edge, unless a boundary event in the same edge sets that flag; set wins.
REQ-024 SHALL keep c_out and the flags unchanged when EN=0 and LOAD=0.
REQ-025 SHALL perform all arithmetic modulo 2^WIDTH with no carry out beyond WIDTH bits.
REQ-026 SHALL treat mod_max=0 as a range of one value: every step is a boundary event and c_out stays 0.

Reset
REQ-027 SHALL, while RST_N=0, immediately force c_out=0, pcnt=0, tc=0, overflow=0 and underflow=0, independent of CLK.
REQ-028 SHALL abandon any partial prescale count on reset; the first step after release needs a full PRESCALE enabled cycles.
REQ-029 SHALL ignore inputs on the edge where RST_N is low; normal operation starts from the first rising edge with RST_N=1.

Verification
REQ-030 SHALL cover wrap-up: WIDTH=4, mod_max=9, UP=1, EN=1 from c_out=0 for 10 cycles -> c_out 1..9, then 0; tc high one cycle; overflow=1 and stays 1.
REQ-031 SHALL cover wrap-down: c_out=0, UP=0, one step -> c_out=9, underflow=1, tc pulse; flag_clr=1 for one cycle -> underflow=0.
REQ-032 SHALL cover saturation: SATURATE=1, mod_max=15, load 14, UP=1 for 3 steps -> c_out 15, 15, 15; overflow=1; tc high once per boundary step.
REQ-033 SHALL cover the prescaler: PRESCALE=3, EN=1 for 9 cycles from 0 -> c_out=3; EN dropped mid-count delays the step by exactly the idle cycles.
REQ-034 SHALL cover priority and clamping: LOAD=1 with EN=1 and load_in=12, mod_max=9 -> c_out=9, no flag; flag_clr with a simultaneous overflow event -> overflow stays 1.
REQ-035 SHALL cover asynchronous reset: RST_N low mid-cycle while c_out=7 and flags set -> all outputs 0 before the next CLK edge; after release, PRESCALE=3 needs 3 enabled cycles before the first step.
